vending_core: RTL and testbench
===============================

# vending_core

Parametrised successor of the vending machine's state/output stage. Accumulates coin credit and dispenses one-hot-selected items subject to price and per-item stock. It returns change as a multi-cycle, one-coin-per-cycle greedy sequence, and auto-returns after an inactivity timeout. Sits between the coin/selection input synchroniser and the dispenser/coin-hopper drivers.

## Interface

Parameters:

- NUM_ITEMS, 4, number of item slots
- NUM_COINS, 3, number of coin denominations; index 0 is the smallest value
- TOTAL_BITS, 16, credit register width
- PRICE_BITS, 16, width of each price and coin value field
- STOCK_BITS, 4, per-item stock counter width
- TIMEOUT_CYCLES, 100, inactivity cycles before auto-return; minimum 1

Ports:

- clk, input, 1, clock; all state updates on the rising edge
- reset_n, input, 1, asynchronous, active-low reset
- i_item_price, input, NUM_ITEMS*PRICE_BITS, packed prices; item k occupies bits [k*PRICE_BITS +: PRICE_BITS]
- i_coin_value, input, NUM_COINS*PRICE_BITS, packed coin values, strictly ascending by index
- i_input_coin, input, NUM_COINS, coins inserted this cycle; multi-hot allowed
- i_select_item, input, NUM_ITEMS, item request; only one-hot values are acted on
- i_trigger_return, input, 1, request change return
- i_restock, input, NUM_ITEMS, set the stock of each flagged item to its maximum
- o_output_item, output, NUM_ITEMS, one-cycle registered dispense pulse
- o_return_coin, output, NUM_COINS, registered one-hot coin ejection, one coin per cycle
- o_available_item, output, NUM_ITEMS, combinational; items purchasable right now
- o_current_total, output, TOTAL_BITS, registered credit
- o_busy, output, 1, registered; high while in RETURN

## Operation

- FSM states: IDLE (total == 0), CREDIT (total > 0), RETURN.
- Reset values: state = IDLE, total = 0, o_output_item = 0, o_return_coin = 0, o_busy = 0, timer = TIMEOUT_CYCLES, every stock = 2^STOCK_BITS-1.
- Coin intake (IDLE/CREDIT): coin_sum is the sum of the values of the asserted coins.
  - If total + coin_sum overflows TOTAL_BITS, all coins of that cycle are rejected and echoed on o_return_coin the next cycle.
  - Otherwise they are credited.
- Selection (IDLE/CREDIT), valid when i_select_item is one-hot with total >= price and stock != 0:
  - o_output_item pulses for one cycle.
  - Stock decrements; total -= price.
  - Multi-hot, zero, insufficient-credit or zero-stock selections are ignored.
- Same-cycle coin and selection: the selection is checked against the pre-cycle total. Next total = total + coin_sum - price.
- Return: i_trigger_return in IDLE/CREDIT, or timer expiry in CREDIT, enters RETURN on the next edge. Coins and selections in that cycle are ignored.
- RETURN: each cycle, o_return_coin = one-hot index of the largest coin value <= total, and total decreases by that value.
  - Exit to IDLE when total < i_coin_value[0].
  - Residual credit below the smallest coin is cleared to 0.
  - All inputs except i_restock are ignored; o_busy = 1.
- Timer:
  - Reloads to TIMEOUT_CYCLES on any accepted coin or dispense.
  - Decrements each CREDIT cycle with no such activity.
  - Expires when it reaches 0 in CREDIT.
  - Held at reload value in IDLE and RETURN.
- Restock: accepted in every state. Restock in the same cycle as a dispense of the same item yields maximum stock.
- o_available_item[k] = !o_busy & (total >= price[k]) & (stock[k] != 0).
- Arithmetic: prices are zero-extended to TOTAL_BITS. A price of 0 is legal and always affordable.

## Timing

- Coin to o_current_total update: 1 cycle.
- Select to o_output_item pulse and total update: 1 cycle.
- Trigger to first o_return_coin: 2 cycles (entry edge, then first ejection edge).
- Return duration: one cycle per ejected coin, plus the exit edge.
- Timeout: TIMEOUT_CYCLES idle cycles in CREDIT, then RETURN.
- reset_n low mid-RETURN or mid-dispense: immediate return to reset values. Pending change is lost; o_return_coin and o_output_item drop without waiting for a clock.

## Structure

- Package vending_pkg holds:
  - the state enum (IDLE, CREDIT, RETURN);
  - default parameter constants;
  - a function that unpacks a price/value field from a packed bus.
- Sub-module vending_timer, parameter TIMEOUT_CYCLES:
  - inputs: clk, reset_n, reload, count_en;
  - output: expired;
  - reset value TIMEOUT_CYCLES.

## Test plan

All scenarios use default parameters, prices {400, 500, 1000, 2000}, coins {100, 500, 1000}.

- Coins 1000 then 500, select item 1 -> total 1500, then output_item 4'b0010 for one cycle, total 1000, stock[1] 14.
- Total 1800, trigger return -> o_return_coin 3'b100, 3'b010, 3'b001, 3'b001, 3'b001 on consecutive cycles, then IDLE with total 0.
- Credit 500, then no activity -> RETURN entered exactly 100 cycles after the last coin; single 3'b010 ejection.
- Select item 0 four times with stock[0] preset to 3 and credit 2000 -> three pulses; fourth ignored; o_available_item[0] = 0; total 800.
- Select 4'b0011 and coin 100 in the same cycle with total 1000 -> no dispense; total 1100.
- reset_n asserted during a 3-coin return -> all outputs 0 immediately; after release, total 0 and stock at maximum.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending machine state/output stage.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    RETURN = 2'd2
  } vend_state_t;

  localparam int DEF_NUM_ITEMS      = 4;
  localparam int DEF_NUM_COINS      = 3;
  localparam int DEF_TOTAL_BITS     = 16;
  localparam int DEF_PRICE_BITS     = 16;
  localparam int DEF_STOCK_BITS     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 100;

  // Widest field and bus the unpack helper handles.
  localparam int FIELD_MAX = 32;
  localparam int BUS_MAX   = 1024;

  function automatic logic [FIELD_MAX-1:0] unpack_field(
    input logic [BUS_MAX-1:0] bus,
    input int                 idx,
    input int                 width
  );
    logic [BUS_MAX-1:0]   shifted;
    logic [FIELD_MAX-1:0] mask;
    shifted = bus >> (idx * width);
    mask    = (width >= FIELD_MAX) ? '1 : ((FIELD_MAX'(1) << width) - FIELD_MAX'(1));
    return shifted[FIELD_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/vending_timer.sv
// Inactivity down-counter; flags expiry while counting down its final cycle.
module vending_timer
  import vending_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload,
  input  logic count_en,
  output logic expired
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD_VAL = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= RELOAD_VAL;
    end else if (reload) begin
      count <= RELOAD_VAL;
    end else if (count_en && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  // Raised on the last counted cycle so the owner leaves CREDIT on the edge
  // where the count reaches zero.
  assign expired = count_en && !reload && (count <= TW'(1));

endmodule

// File: rtl/vending_core.sv
// Vending machine state/output stage: credit, dispense, greedy change return.
//   state  | meaning
//   IDLE   | no credit held
//   CREDIT | credit held, inactivity timer running
//   RETURN | ejecting change one coin per cycle
module vending_core
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS      = DEF_NUM_ITEMS,
  parameter int NUM_COINS      = DEF_NUM_COINS,
  parameter int TOTAL_BITS     = DEF_TOTAL_BITS,
  parameter int PRICE_BITS     = DEF_PRICE_BITS,
  parameter int STOCK_BITS     = DEF_STOCK_BITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_ITEMS*PRICE_BITS-1:0] i_item_price,
  input  logic [NUM_COINS*PRICE_BITS-1:0] i_coin_value,
  input  logic [NUM_COINS-1:0]            i_input_coin,
  input  logic [NUM_ITEMS-1:0]            i_select_item,
  input  logic                            i_trigger_return,
  input  logic [NUM_ITEMS-1:0]            i_restock,
  output logic [NUM_ITEMS-1:0]            o_output_item,
  output logic [NUM_COINS-1:0]            o_return_coin,
  output logic [NUM_ITEMS-1:0]            o_available_item,
  output logic [TOTAL_BITS-1:0]           o_current_total,
  output logic                            o_busy
);

  // Arithmetic width holds total plus a full multi-hot coin sum without wrap.
  localparam int AW = ((TOTAL_BITS > PRICE_BITS) ? TOTAL_BITS : PRICE_BITS) + NUM_COINS;
  localparam logic [AW-1:0]         TOTAL_MAX = AW'({TOTAL_BITS{1'b1}});
  localparam logic [STOCK_BITS-1:0] STOCK_MAX = '1;

  vend_state_t           state;
  logic [STOCK_BITS-1:0] stock [NUM_ITEMS];

  logic [AW-1:0]          price    [NUM_ITEMS];
  logic [AW-1:0]          coin_val [NUM_COINS];
  logic [AW-1:0]          total_ext;
  logic [AW-1:0]          coin_sum;
  logic [AW-1:0]          sel_price;
  logic [AW-1:0]          credit_calc;
  logic [AW-1:0]          eject_val;
  logic [NUM_COINS-1:0]   eject_hot;
  logic [NUM_ITEMS-1:0]   dispense;
  logic [TOTAL_BITS-1:0]  next_credit;
  logic                   coin_ovf;
  logic                   coin_accept;
  logic                   sel_ok;
  logic                   go_return;
  logic                   timer_reload;
  logic                   timer_count;
  logic                   timer_expired;

  assign total_ext = AW'(o_current_total);

  always_comb begin
    for (int k = 0; k < NUM_ITEMS; k++) begin
      price[k] = AW'(unpack_field(BUS_MAX'(i_item_price), k, PRICE_BITS));
    end
    for (int c = 0; c < NUM_COINS; c++) begin
      coin_val[c] = AW'(unpack_field(BUS_MAX'(i_coin_value), c, PRICE_BITS));
    end
  end

  always_comb begin
    coin_sum = '0;
    for (int c = 0; c < NUM_COINS; c++) begin
      if (i_input_coin[c]) coin_sum = coin_sum + coin_val[c];
    end
    coin_ovf    = (total_ext + coin_sum) > TOTAL_MAX;
    coin_accept = (|i_input_coin) && !coin_ovf;
  end

  // Selection is judged against the credit held before this cycle's coins.
  always_comb begin
    sel_ok    = 1'b0;
    sel_price = '0;
    if ($onehot(i_select_item)) begin
      for (int k = 0; k < NUM_ITEMS; k++) begin
        if (i_select_item[k] && (total_ext >= price[k]) && (stock[k] != '0)) begin
          sel_ok    = 1'b1;
          sel_price = price[k];
        end
      end
    end
    credit_calc = total_ext + (coin_ovf ? '0 : coin_sum) - sel_price;
    next_credit = TOTAL_BITS'(credit_calc);
  end

  // Coin values ascend with index, so the last fitting one is the largest.
  always_comb begin
    eject_hot = '0;
    eject_val = '0;
    for (int c = 0; c < NUM_COINS; c++) begin
      if (coin_val[c] <= total_ext) begin
        eject_hot    = '0;
        eject_hot[c] = 1'b1;
        eject_val    = coin_val[c];
      end
    end
  end

  assign go_return = (state != RETURN) &&
                     (i_trigger_return || ((state == CREDIT) && timer_expired));
  assign dispense  = (sel_ok && (state != RETURN) && !go_return) ? i_select_item : '0;

  assign timer_reload = (state != CREDIT) || coin_accept || sel_ok;
  assign timer_count  = (state == CREDIT);

  vending_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .reload  (timer_reload),
    .count_en(timer_count),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      o_current_total <= '0;
      o_output_item   <= '0;
      o_return_coin   <= '0;
      o_busy          <= 1'b0;
      for (int k = 0; k < NUM_ITEMS; k++) stock[k] <= STOCK_MAX;
    end else begin
      // Restock overrides a same-cycle dispense of the same slot.
      for (int k = 0; k < NUM_ITEMS; k++) begin
        if (i_restock[k])      stock[k] <= STOCK_MAX;
        else if (dispense[k])  stock[k] <= stock[k] - STOCK_BITS'(1);
      end
      o_output_item <= dispense;
      case (state)
        IDLE, CREDIT: begin
          if (go_return) begin
            state         <= RETURN;
            o_busy        <= 1'b1;
            o_return_coin <= '0;
          end else begin
            o_current_total <= next_credit;
            o_return_coin   <= coin_ovf ? i_input_coin : '0;
            state           <= (next_credit == '0) ? IDLE : CREDIT;
          end
        end
        RETURN: begin
          if (total_ext < coin_val[0]) begin
            state           <= IDLE;
            o_current_total <= '0;
            o_return_coin   <= '0;
            o_busy          <= 1'b0;
          end else begin
            o_return_coin   <= eject_hot;
            o_current_total <= TOTAL_BITS'(total_ext - eject_val);
          end
        end
        default: begin
          state         <= IDLE;
          o_return_coin <= '0;
          o_busy        <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_available_item = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      o_available_item[k] = !o_busy && (total_ext >= price[k]) && (stock[k] != '0);
    end
  end

endmodule

// File: tb/tb_vending_core.sv
// Directed bench for vending_core: prices {400,500,1000,2000}, coins {100,500,1000}.
module tb_vending_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] item_price;
  logic [47:0] coin_value;
  logic [2:0]  input_coin;
  logic [3:0]  select_item;
  logic        trigger_return;
  logic [3:0]  restock;
  logic [3:0]  output_item;
  logic [2:0]  return_coin;
  logic [3:0]  available_item;
  logic [15:0] current_total;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  vending_core dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_item_price    (item_price),
    .i_coin_value    (coin_value),
    .i_input_coin    (input_coin),
    .i_select_item   (select_item),
    .i_trigger_return(trigger_return),
    .i_restock       (restock),
    .o_output_item   (output_item),
    .o_return_coin   (return_coin),
    .o_available_item(available_item),
    .o_current_total (current_total),
    .o_busy          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_seq [5];
    logic [15:0] exp_tot [5];
    int n1000, n500, n100, nodd, stuck, cnt;

    item_price     = {16'd2000, 16'd1000, 16'd500, 16'd400};
    coin_value     = {16'd1000, 16'd500, 16'd100};
    input_coin     = '0;
    select_item    = '0;
    trigger_return = 1'b0;
    restock        = '0;

    // reset state
    #12;
    chk("rst_total", current_total, 0);
    chk("rst_output", output_item, 0);
    chk("rst_return", return_coin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_avail", available_item, 0);
    chk("rst_stock3", dut.stock[3], 15);
    reset_n = 1'b1;
    tick();

    // coins 1000 then 500, buy item 1
    input_coin = 3'b100; tick();
    chk("coin1000_total", current_total, 1000);
    input_coin = 3'b010; tick(); input_coin = '0;
    chk("coin500_total", current_total, 1500);
    chk("avail_1500", available_item, 4'b0111);
    select_item = 4'b0010; tick(); select_item = '0;
    chk("buy1_pulse", output_item, 4'b0010);
    chk("buy1_total", current_total, 1000);
    chk("buy1_stock", dut.stock[1], 14);
    tick();
    chk("buy1_pulse_drop", output_item, 0);

    // multi-hot select with a coin: no dispense, coin credited
    select_item = 4'b0011; input_coin = 3'b001; tick();
    select_item = '0; input_coin = '0;
    chk("multihot_out", output_item, 0);
    chk("multihot_total", current_total, 1100);

    // drive credit near the top, then overflow
    repeat (40) begin input_coin = 3'b111; tick(); end
    chk("fill_total", current_total, 65100);
    input_coin = 3'b111; tick();
    chk("ovf_echo", return_coin, 3'b111);
    chk("ovf_total", current_total, 65100);
    input_coin = 3'b001; tick(); input_coin = '0;
    chk("post_ovf_total", current_total, 65200);
    chk("post_ovf_echo", return_coin, 0);

    // long greedy return of 65200: 65 x 1000 + 2 x 100
    trigger_return = 1'b1; tick(); trigger_return = 1'b0;
    chk("ret_long_busy", busy, 1);
    chk("ret_long_first", return_coin, 0);
    chk("ret_long_avail", available_item, 0);
    n1000 = 0; n500 = 0; n100 = 0; nodd = 0; stuck = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy) begin stuck = 0; break; end
      case (return_coin)
        3'b100:  n1000++;
        3'b010:  n500++;
        3'b001:  n100++;
        default: nodd++;
      endcase
    end
    chk("ret_long_timeout", stuck, 0);
    chk("ret_long_n1000", n1000, 65);
    chk("ret_long_n500", n500, 0);
    chk("ret_long_n100", n100, 2);
    chk("ret_long_nodd", nodd, 0);
    chk("ret_long_total", current_total, 0);

    // total 1800 return sequence
    input_coin = 3'b111; tick();
    input_coin = 3'b001; tick(); tick(); input_coin = '0;
    chk("t1800_total", current_total, 1800);
    trigger_return = 1'b1; tick(); trigger_return = 1'b0;
    chk("t1800_busy", busy, 1);
    chk("t1800_entry_coin", return_coin, 0);
    exp_seq = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001};
    exp_tot = '{16'd800, 16'd300, 16'd200, 16'd100, 16'd0};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t1800_coin%0d", i), return_coin, exp_seq[i]);
      chk($sformatf("t1800_total%0d", i), current_total, exp_tot[i]);
    end
    tick();
    chk("t1800_exit_coin", return_coin, 0);
    chk("t1800_exit_busy", busy, 0);
    chk("t1800_exit_total", current_total, 0);

    // inactivity timeout from credit 500
    input_coin = 3'b010; tick(); input_coin = '0;
    chk("tmo_total", current_total, 500);
    cnt = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (busy) begin cnt = k; break; end
    end
    chk("tmo_cycles", cnt, 100);
    tick();
    chk("tmo_coin", return_coin, 3'b010);
    chk("tmo_total_after", current_total, 0);
    tick();
    chk("tmo_exit_busy", busy, 0);

    // run stock[0] down to 3, then credit 2000 and buy four times
    restock = 4'b1111; input_coin = 3'b111; tick(); restock = '0;
    tick(); tick(); tick(); input_coin = '0;
    chk("stk_credit", current_total, 6400);
    select_item = 4'b0001;
    repeat (12) tick();
    select_item = '0;
    chk("stk_after12_total", current_total, 1600);
    chk("stk_after12_stock", dut.stock[0], 3);
    input_coin = 3'b001; repeat (4) tick(); input_coin = '0;
    chk("stk_credit2000", current_total, 2000);
    for (int i = 0; i < 4; i++) begin
      select_item = 4'b0001; tick();
      chk($sformatf("stk_buy%0d", i), output_item, (i < 3) ? 4'b0001 : 4'b0000);
    end
    select_item = '0;
    chk("stk_total_800", current_total, 800);
    chk("stk_avail", available_item, 4'b0010);

    // restock in the same cycle as a dispense of that item
    select_item = 4'b0010; restock = 4'b0011; tick();
    select_item = '0; restock = '0;
    chk("rsd_pulse", output_item, 4'b0010);
    chk("rsd_total", current_total, 300);
    chk("rsd_stock1", dut.stock[1], 15);
    chk("rsd_stock0", dut.stock[0], 15);
    chk("rsd_avail", available_item, 0);

    // async reset in the middle of a 3-coin return
    trigger_return = 1'b1; tick(); trigger_return = 1'b0;
    chk("mid_busy", busy, 1);
    tick();
    chk("mid_coin", return_coin, 3'b001);
    chk("mid_total", current_total, 200);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_coin", return_coin, 0);
    chk("arst_out", output_item, 0);
    chk("arst_busy", busy, 0);
    chk("arst_total", current_total, 0);
    #2 reset_n = 1'b1;
    tick();
    chk("post_rst_total", current_total, 0);
    chk("post_rst_coin", return_coin, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post_rst_stock%0d", k), dut.stock[k], 15);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
